mipi_csi_packet_decoder: RTL and testbench

- Sits directly upstream of mipi_rx_raw10_select; consumes the lane-merged 4-byte CSI-2 stream from the byte aligner.
- Parses CSI-2 packet headers, decodes short packets (frame/line sync) into pulses, and strips headers and CRC from long packets.
- Forwards the long-packet payload of the selected data type as one contiguous valid burst per packet, which is the framing the RAW10 unpacker needs.

---
 rtl/mipi_csi_packet_decoder.sv | 154 +++++++++++++++
 tb/tb_mipi_csi_packet_decoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_csi_packet_decoder.sv
// CSI-2 packet decoder: splits the aligned 32-bit lane stream into header fields,
// sync pulses and a contiguous payload burst for the selected long-packet data type.
module mipi_csi_packet_decoder #(
    parameter logic [5:0] DATA_TYPE = 6'h2B,
    parameter logic [1:0] VC        = 2'd0
) (
    input  logic        wb_clk_i,
    input  logic        reset,
    input  logic [31:0] data_i,
    input  logic        data_valid_i,
    output logic [31:0] payload_o,
    output logic        payload_valid_o,
    output logic [2:0]  payload_bytes_o,
    output logic [5:0]  packet_dt_o,
    output logic [15:0] packet_wc_o,
    output logic [7:0]  packet_ecc_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        line_start_o,
    output logic        line_end_o,
    output logic [15:0] line_count_o,
    output logic        err_trunc_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_TRAIL   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_remaining;
    logic        r_match;

    logic [1:0]  w_hdr_vc;
    logic [5:0]  w_hdr_dt;
    logic [15:0] w_hdr_wc;
    logic        w_vc_ok;
    logic        w_is_long;
    logic [2:0]  w_bytes;
    logic [15:0] w_rem_after;

    assign w_hdr_vc    = data_i[7:6];
    assign w_hdr_dt    = data_i[5:0];
    assign w_hdr_wc    = {data_i[23:16], data_i[15:8]};
    assign w_vc_ok     = (w_hdr_vc == VC);
    assign w_is_long   = (w_hdr_dt >= 6'h10);
    // The last word of a packet may carry fewer payload bytes; the rest is CRC.
    assign w_bytes     = (r_remaining > 16'd3) ? 3'd4 : r_remaining[2:0];
    assign w_rem_after = r_remaining - {13'd0, w_bytes};

    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (data_valid_i) begin
                    if (w_is_long && (w_hdr_wc != 16'd0)) begin
                        w_next_state = S_PAYLOAD;
                    end else begin
                        w_next_state = S_TRAIL;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!data_valid_i) begin
                    w_next_state = S_IDLE;
                end else if (w_rem_after == 16'd0) begin
                    w_next_state = S_TRAIL;
                end
            end
            S_TRAIL: begin
                if (!data_valid_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            r_remaining     <= 16'd0;
            r_match         <= 1'b0;
            payload_o       <= 32'd0;
            payload_valid_o <= 1'b0;
            payload_bytes_o <= 3'd0;
            packet_dt_o     <= 6'd0;
            packet_wc_o     <= 16'd0;
            packet_ecc_o    <= 8'd0;
            frame_start_o   <= 1'b0;
            frame_end_o     <= 1'b0;
            line_start_o    <= 1'b0;
            line_end_o      <= 1'b0;
            line_count_o    <= 16'd0;
            err_trunc_o     <= 1'b0;
        end else begin
            payload_valid_o <= 1'b0;
            frame_start_o   <= 1'b0;
            frame_end_o     <= 1'b0;
            line_start_o    <= 1'b0;
            line_end_o      <= 1'b0;
            err_trunc_o     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (data_valid_i) begin
                        packet_dt_o  <= w_hdr_dt;
                        packet_wc_o  <= w_hdr_wc;
                        packet_ecc_o <= data_i[31:24];
                        r_remaining  <= w_hdr_wc;
                        r_match      <= w_is_long && w_vc_ok && (w_hdr_dt == DATA_TYPE);
                        if (!w_is_long && w_vc_ok) begin
                            case (w_hdr_dt)
                                6'h00: begin
                                    frame_start_o <= 1'b1;
                                    line_count_o  <= 16'd0;
                                end
                                6'h01: frame_end_o  <= 1'b1;
                                6'h02: line_start_o <= 1'b1;
                                6'h03: line_end_o   <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (data_valid_i) begin
                        r_remaining <= w_rem_after;
                        if (r_match) begin
                            payload_valid_o <= 1'b1;
                            payload_o       <= data_i;
                            payload_bytes_o <= w_bytes;
                            if ((w_rem_after == 16'd0) && (line_count_o != 16'hFFFF)) begin
                                line_count_o <= line_count_o + 16'd1;
                            end
                        end
                    end else begin
                        err_trunc_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi_packet_decoder.sv
// Bench for mipi_csi_packet_decoder: directed sequences, a packet table and random
// packets checked against a packet-level reference model.
module tb_mipi_csi_packet_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_i;
    logic        data_valid_i;
    logic [31:0] payload_o;
    logic        payload_valid_o;
    logic [2:0]  payload_bytes_o;
    logic [5:0]  packet_dt_o;
    logic [15:0] packet_wc_o;
    logic [7:0]  packet_ecc_o;
    logic        frame_start_o, frame_end_o, line_start_o, line_end_o;
    logic [15:0] line_count_o;
    logic        err_trunc_o;

    mipi_csi_packet_decoder #(.DATA_TYPE(6'h2B), .VC(2'd0)) dut (
        .wb_clk_i(clk), .reset(reset), .data_i(data_i), .data_valid_i(data_valid_i),
        .payload_o(payload_o), .payload_valid_o(payload_valid_o), .payload_bytes_o(payload_bytes_o),
        .packet_dt_o(packet_dt_o), .packet_wc_o(packet_wc_o), .packet_ecc_o(packet_ecc_o),
        .frame_start_o(frame_start_o), .frame_end_o(frame_end_o), .line_start_o(line_start_o),
        .line_end_o(line_end_o), .line_count_o(line_count_o), .err_trunc_o(err_trunc_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [34:0] exp_q[$];           // {bytes, data} of each expected payload beat
    logic [34:0] mon_e;
    logic        prev_pv = 1'b0;
    int c_fs = 0, c_fe = 0, c_ls = 0, c_le = 0, c_trunc = 0, c_beats = 0, c_bursts = 0;
    int s_fs, s_fe, s_ls, s_le, s_trunc, s_beats, s_bursts;
    int m_lc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (frame_start_o) c_fs++;
        if (frame_end_o)   c_fe++;
        if (line_start_o)  c_ls++;
        if (line_end_o)    c_le++;
        if (err_trunc_o)   c_trunc++;
        if (payload_valid_o) begin
            c_beats++;
            if (!prev_pv) c_bursts++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL payload_beat: got unexpected beat 0x%0h, required none", payload_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("payload_data", payload_o, mon_e[31:0]);
                chk("payload_bytes", 32'(payload_bytes_o), 32'(mon_e[34:32]));
            end
        end
        prev_pv = payload_valid_o;
    end

    // ---------------- reference model ----------------
    function automatic logic [2:0] beat_bytes(input int wc, input int i);
        return (wc - 4 * i >= 4) ? 3'd4 : 3'(wc - 4 * i);
    endfunction

    task automatic model_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                             input int nwords, output int e_fs, output int e_fe, output int e_ls,
                             output int e_le, output int e_beats, output int e_trunc);
        int need, sent;
        bit matched;
        e_fs = 0; e_fe = 0; e_ls = 0; e_le = 0; e_beats = 0; e_trunc = 0;
        matched = (dt == 6'h2B) && (vc == 2'd0);
        if (dt < 6'h10) begin
            if (vc == 2'd0) begin
                case (dt)
                    6'h00: begin e_fs = 1; m_lc = 0; end
                    6'h01: e_fe = 1;
                    6'h02: e_ls = 1;
                    6'h03: e_le = 1;
                    default: ;
                endcase
            end
        end else if (wc != 16'd0) begin
            need = (int'(wc) + 3) / 4;
            sent = (nwords < need) ? nwords : need;
            if (matched) e_beats = sent;
            if (sent < need) e_trunc = 1;
            else if (matched && m_lc < 65535) m_lc++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] d, input logic v);
        @(negedge clk);
        data_i       = d;
        data_valid_i = v;
    endtask

    task automatic send_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                               input int nwords, input int ntrail, input logic [7:0] ecc);
        int need, sent;
        bit matched;
        logic [31:0] w;
        matched = (dt == 6'h2B) && (vc == 2'd0);
        drive({ecc, wc, vc, dt}, 1'b1);
        need = (dt >= 6'h10) ? (int'(wc) + 3) / 4 : 0;
        sent = (nwords < need) ? nwords : need;
        for (int i = 0; i < sent; i++) begin
            w = $urandom;
            if (matched) exp_q.push_back({beat_bytes(int'(wc), i), w});
            drive(w, 1'b1);
        end
        if (sent >= need) begin
            for (int i = 0; i < ntrail; i++) drive($urandom, 1'b1);
        end
        drive(32'd0, 1'b0);
        drive(32'd0, 1'b0);
        @(negedge clk);
    endtask

    task automatic snap();
        s_fs = c_fs; s_fe = c_fe; s_ls = c_ls; s_le = c_le;
        s_trunc = c_trunc; s_beats = c_beats; s_bursts = c_bursts;
    endtask

    task automatic check_pkt(input string tag, input int e_fs, input int e_fe, input int e_ls,
                             input int e_le, input int e_beats, input int e_trunc, input int e_lc,
                             input logic [5:0] dt, input logic [15:0] wc, input logic [7:0] ecc);
        chk({tag, ".fs"},     32'(c_fs - s_fs), 32'(e_fs));
        chk({tag, ".fe"},     32'(c_fe - s_fe), 32'(e_fe));
        chk({tag, ".ls"},     32'(c_ls - s_ls), 32'(e_ls));
        chk({tag, ".le"},     32'(c_le - s_le), 32'(e_le));
        chk({tag, ".trunc"},  32'(c_trunc - s_trunc), 32'(e_trunc));
        chk({tag, ".beats"},  32'(c_beats - s_beats), 32'(e_beats));
        chk({tag, ".bursts"}, 32'(c_bursts - s_bursts), (e_beats > 0) ? 32'd1 : 32'd0);
        chk({tag, ".lc"},     32'(line_count_o), 32'(e_lc));
        chk({tag, ".dt"},     32'(packet_dt_o), 32'(dt));
        chk({tag, ".wc"},     32'(packet_wc_o), 32'(wc));
        chk({tag, ".ecc"},    32'(packet_ecc_o), 32'(ecc));
        chk({tag, ".expq"},   32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".payload"}, payload_o, 32'd0);
        chk({tag, ".pv"},      32'(payload_valid_o), 32'd0);
        chk({tag, ".bytes"},   32'(payload_bytes_o), 32'd0);
        chk({tag, ".dt"},      32'(packet_dt_o), 32'd0);
        chk({tag, ".wc"},      32'(packet_wc_o), 32'd0);
        chk({tag, ".ecc"},     32'(packet_ecc_o), 32'd0);
        chk({tag, ".pulses"},  32'({frame_start_o, frame_end_o, line_start_o, line_end_o, err_trunc_o}), 32'd0);
        chk({tag, ".lc"},      32'(line_count_o), 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        int nwords; int ntrail;
        int e_fs; int e_fe; int e_ls; int e_le;
        int e_beats; int e_trunc; int e_lc;
    } vec_t;

    vec_t        vecs[18];
    logic [31:0] raw_w[3];
    logic [2:0]  raw_b[3];
    logic [5:0]  dt_pool[8];
    logic [1:0]  rnd_vc;
    logic [5:0]  rnd_dt;
    logic [15:0] rnd_wc;
    logic [7:0]  rnd_ecc;
    int rnd_nw, rnd_nt, rnd_need;
    int e_fs, e_fe, e_ls, e_le, e_beats, e_trunc;

    initial begin
        reset = 1'b1; data_i = 32'd0; data_valid_i = 1'b0;
        vecs[0]  = '{2'd0, 6'h00, 16'd0,  0, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{2'd0, 6'h02, 16'd0,  0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[2]  = '{2'd0, 6'h2B, 16'd10, 3, 1, 0, 0, 0, 0, 3, 0, 1};
        vecs[3]  = '{2'd0, 6'h2A, 16'd8,  2, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[4]  = '{2'd1, 6'h2B, 16'd10, 3, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[5]  = '{2'd1, 6'h00, 16'd0,  0, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[6]  = '{2'd0, 6'h2B, 16'd20, 2, 0, 0, 0, 0, 0, 2, 1, 1};
        vecs[7]  = '{2'd0, 6'h2B, 16'd0,  0, 2, 0, 0, 0, 0, 0, 0, 1};
        vecs[8]  = '{2'd0, 6'h2B, 16'd7,  2, 1, 0, 0, 0, 0, 2, 0, 2};
        vecs[9]  = '{2'd0, 6'h03, 16'd0,  0, 1, 0, 0, 0, 1, 0, 0, 2};
        vecs[10] = '{2'd0, 6'h08, 16'd0,  0, 0, 0, 0, 0, 0, 0, 0, 2};
        vecs[11] = '{2'd0, 6'h01, 16'd0,  0, 0, 0, 1, 0, 0, 0, 0, 2};
        vecs[12] = '{2'd0, 6'h2B, 16'd1,  1, 1, 0, 0, 0, 0, 1, 0, 3};
        vecs[13] = '{2'd0, 6'h2B, 16'd16, 4, 0, 0, 0, 0, 0, 4, 0, 4};
        vecs[14] = '{2'd0, 6'h00, 16'd0,  0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[15] = '{2'd0, 6'h2B, 16'd5,  0, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[16] = '{2'd0, 6'h10, 16'd8,  1, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[17] = '{2'd0, 6'h0F, 16'd0,  0, 1, 0, 0, 0, 0, 0, 0, 0};
        raw_w = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
        raw_b = '{3'd4, 3'd4, 3'd2};
        dt_pool = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h08, 6'h2B, 6'h2B, 6'h2A};

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // FS (two valid cycles), gap, LE: pulse one cycle after each header
        snap();
        drive(32'h11000000, 1'b1);
        @(posedge clk); #1 chk("fs_pulse", 32'(frame_start_o), 32'd1);
        drive(32'h99999999, 1'b1);
        @(posedge clk); #1 chk("fs_once", 32'(frame_start_o), 32'd0);
        drive(32'd0, 1'b0);
        drive(32'h22000003, 1'b1);
        @(posedge clk); #1 chk("le_pulse", 32'(line_end_o), 32'd1);
        drive(32'd0, 1'b0);
        @(posedge clk); #1 chk("le_once", 32'(line_end_o), 32'd0);
        drive(32'd0, 1'b0);
        @(negedge clk);
        check_pkt("fs_le", 1, 0, 0, 1, 0, 0, 0, 6'h03, 16'h0000, 8'h22);

        // RAW10 line with 10 bytes: 4/4/2, contiguous, drops right after the last word
        snap();
        drive(32'h5A000A2B, 1'b1);
        @(posedge clk); #1 chk("raw10_hdr_pv", 32'(payload_valid_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({raw_b[i], raw_w[i]});
            drive(raw_w[i], 1'b1);
            @(posedge clk); #1;
            chk("raw10_pv", 32'(payload_valid_o), 32'd1);
            chk("raw10_data", payload_o, raw_w[i]);
            chk("raw10_bytes", 32'(payload_bytes_o), 32'(raw_b[i]));
        end
        drive(32'd0, 1'b0);
        @(posedge clk); #1 chk("raw10_pv_end", 32'(payload_valid_o), 32'd0);
        drive(32'd0, 1'b0);
        @(negedge clk);
        check_pkt("raw10", 0, 0, 0, 0, 3, 0, 1, 6'h2B, 16'd10, 8'h5A);

        // Table of packets
        for (int t = 0; t < 18; t++) begin
            snap();
            rnd_ecc = 8'($urandom_range(0, 255));
            send_packet(vecs[t].vc, vecs[t].dt, vecs[t].wc, vecs[t].nwords, vecs[t].ntrail, rnd_ecc);
            check_pkt($sformatf("vec%0d", t), vecs[t].e_fs, vecs[t].e_fe, vecs[t].e_ls, vecs[t].e_le,
                      vecs[t].e_beats, vecs[t].e_trunc, vecs[t].e_lc, vecs[t].dt, vecs[t].wc, rnd_ecc);
        end

        // Reset in the middle of a WC=40 payload
        snap();
        send_packet(2'd0, 6'h2B, 16'd4, 1, 1, 8'hA5);
        check_pkt("pre_rst", 0, 0, 0, 0, 1, 0, 1, 6'h2B, 16'd4, 8'hA5);
        snap();
        drive({8'h3C, 16'd40, 2'd0, 6'h2B}, 1'b1);
        for (int i = 0; i < 3; i++) begin
            raw_w[0] = $urandom;
            exp_q.push_back({3'd4, raw_w[0]});
            drive(raw_w[0], 1'b1);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        data_i = $urandom;
        #1 chk_all_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        data_i = 32'h77000000;
        data_valid_i = 1'b1;
        @(posedge clk); #1 chk("rst_first_hdr", 32'(frame_start_o), 32'd1);
        drive(32'd0, 1'b0);
        drive(32'd0, 1'b0);
        @(negedge clk);
        check_pkt("rst_mid", 1, 0, 0, 0, 3, 0, 0, 6'h00, 16'h0000, 8'h77);

        // Random packets against the reference model
        m_lc = 0;
        for (int k = 0; k < 80; k++) begin
            rnd_vc  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rnd_dt  = dt_pool[$urandom_range(0, 7)];
            rnd_wc  = 16'($urandom_range(0, 24));
            rnd_ecc = 8'($urandom_range(0, 255));
            rnd_need = (int'(rnd_wc) + 3) / 4;
            rnd_nw  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rnd_need)) : rnd_need;
            rnd_nt  = int'($urandom_range(0, 2));
            snap();
            model_pkt(rnd_vc, rnd_dt, rnd_wc, rnd_nw, e_fs, e_fe, e_ls, e_le, e_beats, e_trunc);
            send_packet(rnd_vc, rnd_dt, rnd_wc, rnd_nw, rnd_nt, rnd_ecc);
            check_pkt($sformatf("rnd%0d", k), e_fs, e_fe, e_ls, e_le, e_beats, e_trunc, m_lc,
                      rnd_dt, rnd_wc, rnd_ecc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
